// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 core: chains H0..H7 across pre-padded 512-bit blocks,
// rolling 16-word schedule, ROUNDS_PER_CYCLE rounds per clock. Define SHA224_MODE_EN for SHA-224.
module sha256_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int BLK_CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [511:0]         blk_data,
  input  logic                 blk_first,
  input  logic                 blk_last,
  input  logic                 abort,
`ifdef SHA224_MODE_EN
  input  logic                 mode_224,
`endif
  output logic                 busy,
  output logic                 digest_valid,
  output logic [255:0]         digest,
  output logic [BLK_CNT_W-1:0] blk_count,
  output logic                 seq_err
);

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_UPDATE} state_t;

  generate
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [5:0] LAST_R = 6'(64 - ROUNDS_PER_CYCLE);
  localparam logic [5:0] R_STEP = 6'(ROUNDS_PER_CYCLE);

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam word_t IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA224_MODE_EN
  localparam word_t IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                  32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic word_t sml_s0(input word_t x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);   endfunction
  function automatic word_t sml_s1(input word_t x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction
  function automatic word_t big_s0(input word_t x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
  function automatic word_t big_s1(input word_t x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction

  state_t               state, state_nxt;
  logic [5:0]           r;
  logic                 last_q, chain_active, dv_pend, acc, load_iv;
  word_t                h_reg [8];
  word_t                h_sum [8];
  word_t                iv    [8];
  word_t                wv    [8];
  word_t                win   [16];
  word_t                rw    [8];
  word_t                rwin  [16];
  word_t                t1, t2, w_new;
  logic [255:0]         digest_nxt;
`ifdef SHA224_MODE_EN
  logic                 mode_q;
`endif

  assign blk_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign acc       = blk_valid & blk_ready & ~abort;
  // A block arriving with no open chain starts one, whatever blk_first says.
  assign load_iv   = blk_first | ~chain_active;

  always_comb begin
    iv = IV256;
`ifdef SHA224_MODE_EN
    if (mode_224) iv = IV224;
`endif
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (acc) state_nxt = S_ROUND;
      S_ROUND:  if (r == LAST_R) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Unrolled rounds; the window's word 0 is always W[t] and each round appends W[t+16].
  always_comb begin
    rw    = wv;
    rwin  = win;
    t1    = '0;
    t2    = '0;
    w_new = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      t1    = rw[7] + big_s1(rw[4]) + ((rw[4] & rw[5]) ^ (~rw[4] & rw[6])) + K[r + 6'(j)] + rwin[0];
      t2    = big_s0(rw[0]) + ((rw[0] & rw[1]) ^ (rw[0] & rw[2]) ^ (rw[1] & rw[2]));
      w_new = sml_s1(rwin[14]) + rwin[9] + sml_s0(rwin[1]) + rwin[0];
      rw[7] = rw[6];
      rw[6] = rw[5];
      rw[5] = rw[4];
      rw[4] = rw[3] + t1;
      rw[3] = rw[2];
      rw[2] = rw[1];
      rw[1] = rw[0];
      rw[0] = t1 + t2;
      for (int i = 0; i < 15; i++) rwin[i] = rwin[i+1];
      rwin[15] = w_new;
    end
  end

  always_comb begin
    digest_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h_reg[i] + wv[i];
      digest_nxt[255-32*i -: 32] = h_sum[i];
    end
`ifdef SHA224_MODE_EN
    if (mode_q) digest_nxt[31:0] = '0;
`endif
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      r            <= '0;
      last_q       <= 1'b0;
      chain_active <= 1'b0;
      blk_count    <= '0;
      seq_err      <= 1'b0;
      dv_pend      <= 1'b0;
      digest_valid <= 1'b0;
      digest       <= '0;
      h_reg        <= IV256;
`ifdef SHA224_MODE_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      seq_err      <= acc & (blk_first == chain_active);
      digest_valid <= dv_pend & ~abort;
      dv_pend      <= 1'b0;
      if (abort) begin
        chain_active <= 1'b0;
        blk_count    <= '0;
        r            <= '0;
      end else if (acc) begin
        r      <= '0;
        last_q <= blk_last;
        if (load_iv) begin
          blk_count <= BLK_CNT_W'(1);
          h_reg     <= iv;
`ifdef SHA224_MODE_EN
          mode_q    <= mode_224;
`endif
        end else if (!(&blk_count)) begin
          blk_count <= blk_count + BLK_CNT_W'(1);
        end
      end else if (state == S_ROUND) begin
        r <= r + R_STEP;
      end else if (state == S_UPDATE) begin
        h_reg        <= h_sum;
        chain_active <= ~last_q;
        if (last_q) begin
          digest  <= digest_nxt;
          dv_pend <= 1'b1;
        end
      end
    end
  end

  // NOTE: schedule window and working variables are pure datapath, always loaded on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int t = 0; t < 16; t++) win[t] <= blk_data[511-32*t -: 32];
      if (load_iv) wv <= iv;
      else         wv <= h_reg;
    end else if (state == S_ROUND) begin
      wv  <= rw;
      win <= rwin;
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench for sha256_stream_core: known-answer digests, latency, chaining,
// abort, sequence errors and asynchronous reset (plus SHA-224 when SHA224_MODE_EN is defined).
module tb_sha256_stream_core;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, blk_valid, blk_first, blk_last, abort;
  logic [511:0] blk_data;
  logic         blk_ready, busy, digest_valid, seq_err;
  logic [255:0] digest;
  logic [15:0]  blk_count;
`ifdef SHA224_MODE_EN
  logic         mode_224;
`endif

  logic         v4, f4, l4, ab4, rdy4, busy4, dv4, se4;
  logic [511:0] d4;
  logic [255:0] dg4;
  logic [15:0]  cnt4;

  sha256_stream_core dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .abort(abort),
`ifdef SHA224_MODE_EN
    .mode_224(mode_224),
`endif
    .busy(busy), .digest_valid(digest_valid), .digest(digest), .blk_count(blk_count), .seq_err(seq_err)
  );

  sha256_stream_core #(.ROUNDS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .blk_valid(v4), .blk_ready(rdy4), .blk_data(d4),
    .blk_first(f4), .blk_last(l4), .abort(ab4),
`ifdef SHA224_MODE_EN
    .mode_224(1'b0),
`endif
    .busy(busy4), .digest_valid(dv4), .digest(dg4), .blk_count(cnt4), .seq_err(se4)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitors sample 1 time unit after each rising edge.
  int           dv_n = 0, dv_cyc = 0, se_n = 0, se_cyc = 0, dv4_n = 0, dv4_cyc = 0;
  logic [255:0] dv_dig = '0, dv4_dig = '0;
  always @(posedge clk) begin
    #1;
    if (digest_valid) begin dv_n++;  dv_cyc = cyc;  dv_dig = digest; end
    if (seq_err)      begin se_n++;  se_cyc = cyc; end
    if (dv4)          begin dv4_n++; dv4_cyc = cyc; dv4_dig = dg4; end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [511:0] d, input logic f, input logic l, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    while (!blk_ready && n < 200) begin @(negedge clk); n++; end
    check("send_ready", blk_ready, 1);
    blk_data  = d;
    blk_first = f;
    blk_last  = l;
    blk_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc   = cyc;
    blk_valid = 1'b0;
  endtask

  task automatic wait_dv(input int base, input int budget);
    int n = 0;
    while (dv_n == base && n < budget) begin @(negedge clk); n++; end
    check("dv_arrived", dv_n != base, 1);
  endtask

  int a, a2, n0, s0;

  initial begin
    rst = 1'b0; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0; abort = 1'b0; blk_data = '0;
    v4 = 1'b0; f4 = 1'b0; l4 = 1'b0; ab4 = 1'b0; d4 = '0;
`ifdef SHA224_MODE_EN
    mode_224 = 1'b0;
`endif
    #1;
    check("rst_ready",  blk_ready, 1);
    check("rst_busy",   busy, 0);
    check("rst_dv",     digest_valid, 0);
    check("rst_digest", digest, 0);
    check("rst_count",  blk_count, 0);
    check("rst_seqerr", seq_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single-block "abc"
    n0 = dv_n;
    send(ABC_BLK, 1'b1, 1'b1, a);
    wait_dv(n0, 100);
    check("abc_latency", dv_cyc - a, 66);
    check("abc_digest",  dv_dig, ABC_DIG);
    check("abc_count",   blk_count, 1);
    @(negedge clk);
    check("abc_pulse",   digest_valid, 0);
    check("abc_hold",    digest, ABC_DIG);
    check("abc_dv_once", dv_n - n0, 1);

    // Two-block message, back-to-back issue
    n0 = dv_n;
    send(TWO_B1, 1'b1, 1'b0, a);
    send(TWO_B2, 1'b0, 1'b1, a2);
    check("two_interval", a2 - a, 66);
    wait_dv(n0, 100);
    repeat (3) @(negedge clk);
    check("two_dv_once", dv_n - n0, 1);
    check("two_digest",  dv_dig, TWO_DIG);
    check("two_count",   blk_count, 2);
    check("no_seqerr",   se_n, 0);

    // Empty message on the 4-rounds-per-cycle instance
    begin
      int n = 0;
      @(negedge clk);
      check("r4_ready", rdy4, 1);
      d4 = EMPTY_BLK; f4 = 1'b1; l4 = 1'b1; v4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a  = cyc;
      v4 = 1'b0;
      while (dv4_n == 0 && n < 60) begin @(negedge clk); n++; end
      check("r4_dv_arrived", dv4_n, 1);
      check("r4_latency",    dv4_cyc - a, 18);
      check("r4_digest",     dv4_dig, EMPTY_DIG);
    end

    // Abort during ROUND of block 1 of 2, then "abc"
    n0 = dv_n; s0 = se_n;
    send(TWO_B1, 1'b1, 1'b0, a);
    repeat (10) @(negedge clk);
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle",  busy, 0);
    check("abort_count", blk_count, 0);
    repeat (80) @(negedge clk);
    check("abort_no_dv", dv_n - n0, 0);
    check("abort_digest_kept", digest, TWO_DIG);
    send(ABC_BLK, 1'b1, 1'b1, a);
    wait_dv(n0, 100);
    check("post_abort_digest", dv_dig, ABC_DIG);
    check("post_abort_seqerr", se_n - s0, 0);

    // Abort coinciding with a handshake drops the block
    n0 = dv_n;
    @(negedge clk);
    blk_data = ABC_BLK; blk_first = 1'b1; blk_last = 1'b1; blk_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0; abort = 1'b0;
    check("abort_hs_idle",  busy, 0);
    check("abort_hs_count", blk_count, 0);
    repeat (70) @(negedge clk);
    check("abort_hs_no_dv", dv_n - n0, 0);

    // blk_first=1 mid-chain restarts from IV
    n0 = dv_n; s0 = se_n;
    send(TWO_B1, 1'b1, 1'b0, a);
    send(ABC_BLK, 1'b1, 1'b1, a);
    check("restart_seqerr",     se_n - s0, 1);
    check("restart_seqerr_cyc", se_cyc, a);
    wait_dv(n0, 100);
    check("restart_digest", dv_dig, ABC_DIG);
    check("restart_count",  blk_count, 1);

    // blk_first=0 with no open chain is treated as first
    n0 = dv_n; s0 = se_n;
    send(ABC_BLK, 1'b0, 1'b1, a);
    check("orphan_seqerr", se_n - s0, 1);
    wait_dv(n0, 100);
    check("orphan_digest", dv_dig, ABC_DIG);

`ifdef SHA224_MODE_EN
    n0 = dv_n;
    mode_224 = 1'b1;
    send(ABC_BLK, 1'b1, 1'b1, a);
    mode_224 = 1'b0;
    wait_dv(n0, 100);
    check("sha224_digest", dv_dig,
          256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000);
`endif

    // Asynchronous reset mid-ROUND
    n0 = dv_n;
    send(ABC_BLK, 1'b1, 1'b1, a);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy",   busy, 0);
    check("mid_rst_ready",  blk_ready, 1);
    check("mid_rst_digest", digest, 0);
    check("mid_rst_count",  blk_count, 0);
    check("mid_rst_dv",     digest_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    check("mid_rst_no_dv", dv_n - n0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
